// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg -- shared stage-register state encoding and per-stage payload layouts (rev 1.0)
`default_nettype none
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // MEM->WB payload: {RF_LE, L, rd[4:0], alu[31:0], mem[31:0], pc8[31:0]}
  localparam int MEMWB_W        = 103;
  localparam int MEMWB_PC8_LSB  = 0;
  localparam int MEMWB_MEM_LSB  = 32;
  localparam int MEMWB_ALU_LSB  = 64;
  localparam int MEMWB_RD_LSB   = 96;
  localparam int MEMWB_L_BIT    = 101;
  localparam int MEMWB_RFLE_BIT = 102;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if -- one valid/ready payload channel between pipeline stages (rev 1.0)
`default_nettype none
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = MEMWB_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- valid/ready pipeline stage register with flush and optional skid entry (rev 1.0)
`default_nettype none
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W  = MEMWB_W,
  parameter bit              SKID    = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        flush,
  pipe_stage_skid_if.slave  s_in,
  pipe_stage_skid_if.master m_out,
  output logic [1:0]       occupancy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = s_in.valid & w_in_ready;
  assign w_out_fire  = w_out_valid & m_out.ready;

  assign m_out.valid = w_out_valid;
  assign m_out.data  = r_main;
  assign s_in.ready  = w_in_ready;
  assign occupancy   = occ_of(r_state);

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_BUSY;
          w_load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire && SKID) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush discards everything, including a beat accepted on this edge.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main <= s_in.data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= s_in.data;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready <= 1'b0;
        end else begin
          r_in_ready <= (w_state_nxt != ST_FULL);
        end
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = ~reset & (m_out.ready | ~w_out_valid);
    end
  endgenerate

`ifndef SYNTHESIS
  a_no_accept_full : assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_FULL) |-> !w_in_fire);
  a_legal_state : assert property (@(posedge clk) disable iff (reset)
    r_state inside {ST_EMPTY, ST_BUSY, ST_FULL});
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid -- skid and non-skid builds driven in parallel against queue models (rev 1.0)
`default_nettype none
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int DW = MEMWB_W;
  typedef logic [DW-1:0] data_t;

  logic  clk       = 1'b0;
  logic  reset     = 1'b1;
  logic  flush     = 1'b0;
  logic  in_valid  = 1'b0;
  logic  out_ready = 1'b0;
  data_t in_data   = '0;
  logic [1:0] occ1;
  logic [1:0] occ0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  data_t q1[$];
  data_t q0[$];
  logic  m_rdy1 = 1'b0;

  pipe_stage_skid_if #(.DATA_W(DW)) in1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) out1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) in0 ();
  pipe_stage_skid_if #(.DATA_W(DW)) out0 ();

  assign in1.valid  = in_valid;
  assign in1.data   = in_data;
  assign out1.ready = out_ready;
  assign in0.valid  = in_valid;
  assign in0.data   = in_data;
  assign out0.ready = out_ready;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .RST_VAL('0)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_in(in1), .m_out(out1), .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .RST_VAL('0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_in(in0), .m_out(out0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: commits accepted and delivered beats on every edge.
  initial begin
    logic f_in1, f_out1, f_in0, f_out0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q1.delete();
        q0.delete();
        m_rdy1 = 1'b0;
      end else begin
        f_in1  = in_valid && m_rdy1;
        f_out1 = (q1.size() != 0) && out_ready;
        f_in0  = in_valid && (out_ready || q0.size() == 0);
        f_out0 = (q0.size() != 0) && out_ready;
        if (flush) begin
          q1.delete();
          q0.delete();
        end else begin
          if (f_out1) void'(q1.pop_front());
          if (f_in1)  q1.push_back(in_data);
          if (f_out0) void'(q0.pop_front());
          if (f_in0)  q0.push_back(in_data);
        end
        m_rdy1 = (q1.size() < 2);
      end
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("skid_valid", out1.valid, q1.size() != 0);
      chk("skid_occ",   occ1, q1.size());
      chk("skid_ready", in1.ready, m_rdy1);
      if (q1.size() != 0) chk("skid_data", out1.data, q1[0]);
      chk("noskid_valid", out0.valid, q0.size() != 0);
      chk("noskid_occ",   occ0, q0.size());
      chk("noskid_ready", in0.ready, !reset && (out_ready || q0.size() == 0));
      if (q0.size() != 0) chk("noskid_data", out0.data, q0[0]);
    end
  end

  task automatic drive(input logic v, input data_t d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] t;
    // Reset held with a pending upstream beat
    in_valid = 1'b1;
    in_data  = data_t'(128'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid1", out1.valid, 1'b0);
    chk("rst_occ1",   occ1, 2'd0);
    chk("rst_ready1", in1.ready, 1'b0);
    chk("rst_ready0", in0.ready, 1'b0);
    chk("rst_data1",  out1.data, '0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ready1", in1.ready, 1'b1);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) drive(1'b1, data_t'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Downstream stall with upstream holding 0xC
    drive(1'b1, data_t'(128'hA), 1'b1, 1'b0);
    drive(1'b1, data_t'(128'hB), 1'b0, 1'b0);
    repeat (2) drive(1'b1, data_t'(128'hC), 1'b0, 1'b0);
    drive(1'b1, data_t'(128'hC), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with a beat offered
    drive(1'b1, data_t'(128'h11), 1'b0, 1'b0);
    drive(1'b1, data_t'(128'h12), 1'b0, 1'b0);
    drive(1'b1, data_t'(128'hD), 1'b0, 1'b1);
    chk("flush_valid1", out1.valid, 1'b0);
    chk("flush_occ1",   occ1, 2'd0);
    chk("flush_valid0", out0.valid, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full
    drive(1'b1, data_t'(128'h21), 1'b0, 1'b0);
    drive(1'b1, data_t'(128'h22), 1'b0, 1'b0);
    chk("pre_areset_occ1", occ1, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid1", out1.valid, 1'b0);
    chk("areset_occ1",   occ1, 2'd0);
    chk("areset_valid0", out0.valid, 1'b0);
    chk("areset_ready1", in1.ready, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), t[DW-1:0], ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 63) == 0));
    end
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
